// File: rtl/pop_counter_pkg.sv
// Shared definitions for the pop counter bank.
//   state_t   : request FSM encoding (S_READY=0, S_PEND=1)
//   DEF_*     : default channel count / counter width / index width
//   MODE_*    : overflow behaviour selectors for SAT_MODE
package pop_counter_pkg;

  typedef enum logic {
    S_READY = 1'b0,
    S_PEND  = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 5;
  localparam int DEF_CNT_W  = 5;
  localparam int DEF_IDX_W  = 3;

  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;

endpackage

// File: rtl/pop_counter_cell.sv
// Single channel pop counter with wrap/saturate overflow and sticky ovf.
//   CLK   : clock, rising edge
//   reset : async active-low reset
//   inc   : count one pop this cycle
//   clr   : serviced clear-on-read; restarts the count (keeps a same-cycle pop)
//   cnt   : current count
//   ovf   : sticky overflow flag, cleared by reset or clr
module pop_counter_cell
  import pop_counter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      // Counter restarts, so a coincident pop can never overflow here.
      cnt <= inc ? CNT_W'(1) : '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == MAX) begin
        ovf <= 1'b1;
        cnt <= (SAT_MODE == MODE_SAT) ? MAX : '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pop_counter_bank.sv
// Per-channel pop counter bank with a one-deep pending read request.
//   CLK   : clock, rising edge
//   reset : async active-low reset
//   pop   : per-channel pop strobes
//   req   : read request strobe, idx sampled with it
//   IDLE  : reads are serviced only while high
//   idx   : channel select
//   data  : registered count of the serviced channel (holds when valid=0)
//   valid : one-cycle qualifier per serviced request
//   err   : with valid, the serviced idx was out of range (data=0)
//   ovf   : sticky per-channel overflow flags
//   busy  : a request is pending on IDLE
module pop_counter_bank
  import pop_counter_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int SAT_MODE    = MODE_WRAP,
  parameter int CLR_ON_READ = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic              IDLE,
  input  logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  data,
  output logic              valid,
  output logic              err,
  output logic [NUM_CH-1:0] ovf,
  output logic              busy
);

  state_t                        state, state_d;
  logic [IDX_W-1:0]              idx_q;
  logic                          svc, latch;
  logic [IDX_W-1:0]              svc_idx;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0]             clr;
  logic [CNT_W-1:0]              rd_val;
  logic                          hit;

  // FSM next state; decides when a read is serviced and with which index
  always_comb begin
    state_d = state;
    svc     = 1'b0;
    latch   = 1'b0;
    svc_idx = idx;
    case (state)
      S_READY: begin
        if (req && IDLE) begin
          svc = 1'b1;
        end else if (req) begin
          latch   = 1'b1;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        // req is ignored while pending: no queueing
        svc_idx = idx_q;
        if (IDLE) begin
          svc     = 1'b1;
          state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  // Read mux; an index beyond NUM_CH matches nothing and returns 0
  always_comb begin
    rd_val = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (svc_idx == IDX_W'(i)) begin
        rd_val = cnt[i];
        hit    = 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign clr[g] = (CLR_ON_READ != 0) && svc && (svc_idx == IDX_W'(g));

      pop_counter_cell #(
        .CNT_W    (CNT_W),
        .SAT_MODE (SAT_MODE)
      ) u_cell (
        .CLK   (CLK),
        .reset (reset),
        .inc   (pop[g]),
        .clr   (clr[g]),
        .cnt   (cnt[g]),
        .ovf   (ovf[g])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= S_READY;
      idx_q <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      if (latch) idx_q <= idx;
      valid <= svc;
      err   <= svc && !hit;
      // Pre-increment value: the counter updates on this same edge
      if (svc) data <= rd_val;
    end
  end

  assign busy = (state == S_PEND);

endmodule

// File: tb/tb_pop_counter_bank.sv
// Scoreboard bench: three bank instances (wrap, saturate, clear-on-read)
// share one stimulus stream; each has its own expected-response queue
// that a negedge monitor drains whenever valid is seen.
module tb_pop_counter_bank;

  typedef struct {
    logic [4:0] data;
    logic       err;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] pop;
  logic       req, IDLE;
  logic [2:0] idx;

  logic [4:0] data_a, data_s, data_c;
  logic       valid_a, valid_s, valid_c;
  logic       err_a, err_s, err_c;
  logic [4:0] ovf_a, ovf_s, ovf_c;
  logic       busy_a, busy_s, busy_c;

  exp_t q_a[$], q_s[$], q_c[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  pop_counter_bank #(.SAT_MODE(0), .CLR_ON_READ(0)) dut_a (
    .CLK(CLK), .reset(reset), .pop(pop), .req(req), .IDLE(IDLE), .idx(idx),
    .data(data_a), .valid(valid_a), .err(err_a), .ovf(ovf_a), .busy(busy_a));

  pop_counter_bank #(.SAT_MODE(1), .CLR_ON_READ(0)) dut_s (
    .CLK(CLK), .reset(reset), .pop(pop), .req(req), .IDLE(IDLE), .idx(idx),
    .data(data_s), .valid(valid_s), .err(err_s), .ovf(ovf_s), .busy(busy_s));

  pop_counter_bank #(.SAT_MODE(0), .CLR_ON_READ(1)) dut_c (
    .CLK(CLK), .reset(reset), .pop(pop), .req(req), .IDLE(IDLE), .idx(idx),
    .data(data_c), .valid(valid_c), .err(err_c), .ovf(ovf_c), .busy(busy_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: valid with no expected response", nm);
  endtask

  // Monitor: compare every valid against the head of that instance's queue
  always @(negedge CLK) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) unexpected("a.valid");
      else begin
        e = q_a.pop_front();
        chk("a.data", 32'(data_a), 32'(e.data));
        chk("a.err", 32'(err_a), 32'(e.err));
      end
    end
    if (valid_s) begin
      if (q_s.size() == 0) unexpected("s.valid");
      else begin
        e = q_s.pop_front();
        chk("s.data", 32'(data_s), 32'(e.data));
        chk("s.err", 32'(err_s), 32'(e.err));
      end
    end
    if (valid_c) begin
      if (q_c.size() == 0) unexpected("c.valid");
      else begin
        e = q_c.pop_front();
        chk("c.data", 32'(data_c), 32'(e.data));
        chk("c.err", 32'(err_c), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect3(input logic [4:0] da, input logic [4:0] ds,
                         input logic [4:0] dc, input logic er);
    q_a.push_back('{data: da, err: er});
    q_s.push_back('{data: ds, err: er});
    q_c.push_back('{data: dc, err: er});
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      pop = 5'(1 << ch);
      tick();
    end
    pop = '0;
  endtask

  task automatic rd(input int ch, input logic [4:0] da, input logic [4:0] ds,
                    input logic [4:0] dc, input logic er);
    expect3(da, ds, dc, er);
    req  = 1'b1;
    idx  = 3'(ch);
    IDLE = 1'b1;
    tick();
    req  = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".a"}, 32'({data_a, valid_a, err_a, ovf_a, busy_a}), 32'd0);
    chk({nm, ".s"}, 32'({data_s, valid_s, err_s, ovf_s, busy_s}), 32'd0);
    chk({nm, ".c"}, 32'({data_c, valid_c, err_c, ovf_c, busy_c}), 32'd0);
  endtask

  initial begin
    pop = '0; req = 1'b0; idx = '0; IDLE = 1'b1; reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    tick();

    // basic read: 3 pops on ch2
    pulse(2, 3);
    rd(2, 5'd3, 5'd3, 5'd3, 1'b0);

    // pending read on ch4 while IDLE low; second req (idx=1) is dropped
    pulse(4, 5);
    expect3(5'd5, 5'd5, 5'd5, 1'b0);
    req = 1'b1; idx = 3'd4; IDLE = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("pend.busy_a", 32'(busy_a), 32'd1);
      chk("pend.busy_c", 32'(busy_c), 32'd1);
      req = (k == 1);
      idx = 3'd1;
      tick();
    end
    req = 1'b0; IDLE = 1'b1;
    tick();
    chk("pend.busy_done", 32'(busy_a), 32'd0);
    repeat (3) tick();

    // overflow: 33 pops on ch0 -> wrap gives 1, saturate gives 31
    pulse(0, 33);
    chk("ovf.a", 32'(ovf_a), 32'd1);
    chk("ovf.s", 32'(ovf_s), 32'd1);
    chk("ovf.c", 32'(ovf_c), 32'd1);
    rd(0, 5'd1, 5'd31, 5'd1, 1'b0);
    chk("ovf_after_rd.a", 32'(ovf_a), 32'd1);
    chk("ovf_after_rd.s", 32'(ovf_s), 32'd1);
    chk("ovf_after_rd.c", 32'(ovf_c), 32'd0);

    // read ch1 with a same-cycle pop: pre-increment value returned
    pulse(1, 7);
    expect3(5'd7, 5'd7, 5'd7, 1'b0);
    req = 1'b1; idx = 3'd1; pop = 5'b00010;
    tick();
    req = 1'b0; pop = '0;
    tick();
    rd(1, 5'd8, 5'd8, 5'd1, 1'b0);
    chk("ovf1.c", 32'(ovf_c[1]), 32'd0);

    // out-of-range index, then counters unchanged (clear-on-read bank emptied ch1)
    rd(6, 5'd0, 5'd0, 5'd0, 1'b1);
    rd(1, 5'd8, 5'd8, 5'd0, 1'b0);

    // reset while a ch3 request is pending
    pulse(3, 9);
    req = 1'b1; idx = 3'd3; IDLE = 1'b0;
    tick();
    req = 1'b0;
    chk("rstpend.busy", 32'(busy_a), 32'd1);
    #2 reset = 1'b0;
    #1 chk_zero("rst_mid");
    @(posedge CLK);
    #1 reset = 1'b1;
    IDLE = 1'b1;
    repeat (3) tick();
    rd(3, 5'd0, 5'd0, 5'd0, 1'b0);

    // drain: every expected response must have been seen
    for (int k = 0; k < 10 && (q_a.size() + q_s.size() + q_c.size()) != 0; k++) tick();
    chk("drain", 32'(q_a.size() + q_s.size() + q_c.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
